// File: rtl/register_universal_nbit_negclk_if.sv
// Register bus: control, data and serial inputs plus outputs.
// Master drives operations, slave is the register.
interface register_universal_nbit_negclk_if #(
  parameter int WIDTH = 8
);
  logic             Enbar;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] D;
  logic             SerInR;
  logic             SerInL;
  logic [WIDTH-1:0] Q;
  logic             Cout;
  logic             Zero;

  modport master (
    output Enbar, Mode, D, SerInR, SerInL,
    input  Q, Cout, Zero
  );

  modport slave (
    input  Enbar, Mode, D, SerInR, SerInL,
    output Q, Cout, Zero
  );
endinterface

// File: rtl/register_universal_nbit_negclk.sv
// Universal N-bit register on the falling clock edge:
// hold/load/shift/rotate/inc/dec with a registered carry flag.
module register_universal_nbit_negclk #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic ClkN,
  input logic Clr,
  register_universal_nbit_negclk_if.slave bus
);

  typedef enum logic [2:0] {
    MHOLD = 3'b000,
    MLOAD = 3'b001,
    MSHR  = 3'b010,
    MSHL  = 3'b011,
    MROR  = 3'b100,
    MROL  = 3'b101,
    MINC  = 3'b110,
    MDEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] qReg;
  logic             coutReg;
  logic [WIDTH-1:0] nextQ;
  logic             nextCout;
  mode_e            mode;

  assign mode = mode_e'(bus.Mode);

  // Next value of Q and Cout for the selected operation.
  always_comb begin
    nextQ    = qReg;
    nextCout = coutReg;
    unique case (mode)
      MHOLD: begin
        nextQ    = qReg;
        nextCout = coutReg;
      end
      MLOAD: begin
        nextQ    = bus.D;
        nextCout = 1'b0;
      end
      MSHR: begin
        nextQ    = {bus.SerInR, qReg[WIDTH-1:1]};
        nextCout = qReg[0];
      end
      MSHL: begin
        nextQ    = {qReg[WIDTH-2:0], bus.SerInL};
        nextCout = qReg[WIDTH-1];
      end
      MROR: begin
        nextQ    = {qReg[0], qReg[WIDTH-1:1]};
        nextCout = qReg[0];
      end
      MROL: begin
        nextQ    = {qReg[WIDTH-2:0], qReg[WIDTH-1]};
        nextCout = qReg[WIDTH-1];
      end
      MINC: begin
        nextQ    = qReg + 1'b1;
        nextCout = &qReg;
      end
      MDEC: begin
        nextQ    = qReg - 1'b1;
        nextCout = ~|qReg;
      end
      default: begin
        nextQ    = qReg;
        nextCout = coutReg;
      end
    endcase
  end

  // Falling-edge state: Clr first, then the active-low enable.
  always_ff @(negedge ClkN) begin
    if (Clr) begin
      qReg    <= RESET_VALUE;
      coutReg <= 1'b0;
    end else if (!bus.Enbar) begin
      qReg    <= nextQ;
      coutReg <= nextCout;
    end
  end

  assign bus.Q    = qReg;
  assign bus.Cout = coutReg;
  assign bus.Zero = ~|qReg;

endmodule
